// File: rtl/seqdet_pkg.sv
// Shared definitions for the run-length sequence detector: mode encodings,
// run-counter sizing and the mode/symbol gating rule.
package seqdet_pkg;

   localparam logic [1:0] MODE_NONE  = 2'b00;
   localparam logic [1:0] MODE_ONES  = 2'b01;
   localparam logic [1:0] MODE_ZEROS = 2'b10;
   localparam logic [1:0] MODE_BOTH  = 2'b11;

   // Bits needed to hold a run length of 0..run_len inclusive.
   function automatic int run_cnt_w(input int run_len);
      return (run_len < 1) ? 1 : $clog2(run_len + 1);
   endfunction

   function automatic logic mode_permits(input logic [1:0] mode, input logic sym);
      logic ok;
      case (mode)
         MODE_ONES:  ok = sym;
         MODE_ZEROS: ok = ~sym;
         MODE_BOTH:  ok = 1'b1;
         default:    ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/run_length_detector_sat_counter.sv
// Saturating event counter with a sticky all-ones flag and a clear that
// takes priority over a simultaneous increment.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q,
   output logic         sat
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         sat_q, sat_d;

   function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
      return (v == {W{1'b1}}) ? v : v + W'(1);
   endfunction

   always_comb begin
      cnt_d = cnt_q;
      sat_d = sat_q;
      if (clr) begin
         cnt_d = '0;
         sat_d = 1'b0;
      end else if (inc) begin
         cnt_d = sat_inc(cnt_q);
         sat_d = sat_q | (cnt_d == {W{1'b1}});
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q <= '0;
         sat_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sat_q <= sat_d;
      end
   end

   assign q   = cnt_q;
   assign sat = sat_q;

endmodule

// File: rtl/run_length_detector.sv
// Flags RUN_LEN consecutive identical samples of w, with polarity mode,
// overlapping/restart detection, sample enable and a saturating match count.
module run_length_detector
   import seqdet_pkg::*;
#(
   parameter int RUN_LEN = 4,
   parameter int CNT_W   = 8
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          en,
   input  logic                          w,
   input  logic [1:0]                    mode,
   input  logic                          overlap,
   input  logic                          clr_count,
   output logic                          z,
   output logic                          z_val,
   output logic [$clog2(RUN_LEN+1)-1:0]  run_len_o,
   output logic [CNT_W-1:0]              det_count,
   output logic                          det_sat
);

   localparam int            RW      = run_cnt_w(RUN_LEN);
   localparam logic [RW-1:0] RUN_MAX = RW'(RUN_LEN);

   logic          last_q, last_d;
   logic [RW-1:0] run_q, run_d;
   logic          z_q, z_d;
   logic          zval_q, zval_d;
   logic [RW-1:0] run_upd;
   logic          match;

   // Run length clamps at RUN_MAX so an overlapping run keeps matching.
   function automatic logic [RW-1:0] run_inc(input logic [RW-1:0] r);
      return (r >= RUN_MAX) ? RUN_MAX : r + RW'(1);
   endfunction

   always_comb begin
      last_d  = last_q;
      run_d   = run_q;
      z_d     = 1'b0;
      zval_d  = zval_q;
      run_upd = run_q;
      match   = 1'b0;
      if (en) begin
         if (run_q == '0 || w != last_q) begin
            run_upd = RW'(1);
            last_d  = w;
         end else begin
            run_upd = run_inc(run_q);
         end
         match = (run_upd == RUN_MAX) && mode_permits(mode, w);
         run_d = run_upd;
         if (match) begin
            z_d    = 1'b1;
            zval_d = w;
            if (!overlap) run_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         last_q <= 1'b0;
         run_q  <= '0;
         z_q    <= 1'b0;
         zval_q <= 1'b0;
      end else begin
         last_q <= last_d;
         run_q  <= run_d;
         z_q    <= z_d;
         zval_q <= zval_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_det_cnt (
      .clk    (clk),
      .resetn (resetn),
      .clr    (clr_count),
      .inc    (match),
      .q      (det_count),
      .sat    (det_sat)
   );

   assign z         = z_q;
   assign z_val     = zval_q;
   assign run_len_o = run_q;

endmodule

// File: tb/tb_run_length_detector.sv
// Directed bench for run_length_detector: a default instance, a CNT_W=2
// instance for saturation and a RUN_LEN=1 instance, all sharing one input set.
module tb_run_length_detector;

   logic       clk = 1'b0;
   logic       resetn, en, w, overlap, clr_count;
   logic [1:0] mode;

   logic       z_a, zv_a, sat_a;
   logic [2:0] run_a;
   logic [7:0] cnt_a;

   logic       z_b, zv_b, sat_b;
   logic [2:0] run_b;
   logic [1:0] cnt_b;

   logic       z_c, zv_c, sat_c;
   logic [0:0] run_c;
   logic [7:0] cnt_c;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   run_length_detector #(.RUN_LEN(4), .CNT_W(8)) dut_a (
      .clk(clk), .resetn(resetn), .en(en), .w(w), .mode(mode), .overlap(overlap),
      .clr_count(clr_count), .z(z_a), .z_val(zv_a), .run_len_o(run_a),
      .det_count(cnt_a), .det_sat(sat_a));

   run_length_detector #(.RUN_LEN(4), .CNT_W(2)) dut_b (
      .clk(clk), .resetn(resetn), .en(en), .w(w), .mode(mode), .overlap(overlap),
      .clr_count(clr_count), .z(z_b), .z_val(zv_b), .run_len_o(run_b),
      .det_count(cnt_b), .det_sat(sat_b));

   run_length_detector #(.RUN_LEN(1), .CNT_W(8)) dut_c (
      .clk(clk), .resetn(resetn), .en(en), .w(w), .mode(mode), .overlap(overlap),
      .clr_count(clr_count), .z(z_c), .z_val(zv_c), .run_len_o(run_c),
      .det_count(cnt_c), .det_sat(sat_c));

   task automatic step(input logic wv, input logic env);
      w  = wv;
      en = env;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      en     = 1'b1;
      w      = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      mode = 2'b11; overlap = 1'b1; clr_count = 1'b0;
      do_reset();
      n_vec++; if ({z_a, zv_a, run_a, cnt_a, sat_a} !== 14'd0) begin
         n_err++; $display("FAIL reset_state: got %h expected 0", {z_a, zv_a, run_a, cnt_a, sat_a});
      end
      step(1, 1); step(1, 1);
      n_vec++; if (run_a !== 3'd2) begin
         n_err++; $display("FAIL reset_prerun: got run=%0d expected 2", run_a);
      end
      do_reset();
      n_vec++; if (run_a !== 3'd0) begin
         n_err++; $display("FAIL reset_midrun: got run=%0d expected 0", run_a);
      end
      step(1, 1); step(1, 1); step(1, 1);
      n_vec++; if (z_a !== 1'b0 || run_a !== 3'd3 || cnt_a !== 8'd0) begin
         n_err++; $display("FAIL reset_after: got z=%0b run=%0d cnt=%0d expected z=0 run=3 cnt=0", z_a, run_a, cnt_a);
      end
   endtask

   task automatic test_overlap();
      mode = 2'b11; overlap = 1'b1;
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         step(1, 1);
         n_vec++; if (z_a !== (i >= 4)) begin
            n_err++; $display("FAIL ovl_z_edge%0d: got %0b expected %0b", i, z_a, (i >= 4));
         end
      end
      n_vec++; if (zv_a !== 1'b1 || cnt_a !== 8'd3 || run_a !== 3'd4) begin
         n_err++; $display("FAIL ovl_final: got zval=%0b cnt=%0d run=%0d expected zval=1 cnt=3 run=4", zv_a, cnt_a, run_a);
      end
   endtask

   task automatic test_nonoverlap();
      logic [2:0] exp_run;
      mode = 2'b11; overlap = 1'b0;
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         step(1, 1);
         exp_run = (i % 4 == 0) ? 3'd0 : 3'(i % 4);
         n_vec++; if (z_a !== (i % 4 == 0) || run_a !== exp_run) begin
            n_err++; $display("FAIL novl_edge%0d: got z=%0b run=%0d expected z=%0b run=%0d", i, z_a, run_a, (i % 4 == 0), exp_run);
         end
      end
      n_vec++; if (cnt_a !== 8'd2) begin
         n_err++; $display("FAIL novl_count: got %0d expected 2", cnt_a);
      end
   endtask

   task automatic test_mode();
      mode = 2'b01; overlap = 1'b1;
      do_reset();
      for (int i = 1; i <= 4; i++) step(0, 1);
      n_vec++; if (z_a !== 1'b0 || run_a !== 3'd4) begin
         n_err++; $display("FAIL mode_ones_blocks: got z=%0b run=%0d expected z=0 run=4", z_a, run_a);
      end
      mode = 2'b11;
      step(0, 1);
      n_vec++; if (z_a !== 1'b1 || zv_a !== 1'b0) begin
         n_err++; $display("FAIL mode_switch: got z=%0b zval=%0b expected z=1 zval=0", z_a, zv_a);
      end
      mode = 2'b00;
      step(0, 1);
      n_vec++; if (z_a !== 1'b0 || cnt_a !== 8'd1) begin
         n_err++; $display("FAIL mode_none: got z=%0b cnt=%0d expected z=0 cnt=1", z_a, cnt_a);
      end
   endtask

   task automatic test_enable();
      mode = 2'b11; overlap = 1'b1;
      do_reset();
      step(1, 1); step(1, 1);
      for (int i = 0; i < 3; i++) begin
         step(0, 0);
         n_vec++; if (z_a !== 1'b0 || run_a !== 3'd2) begin
            n_err++; $display("FAIL en_hold%0d: got z=%0b run=%0d expected z=0 run=2", i, z_a, run_a);
         end
      end
      step(1, 1);
      n_vec++; if (z_a !== 1'b0 || run_a !== 3'd3) begin
         n_err++; $display("FAIL en_third: got z=%0b run=%0d expected z=0 run=3", z_a, run_a);
      end
      step(1, 1);
      n_vec++; if (z_a !== 1'b1 || zv_a !== 1'b1) begin
         n_err++; $display("FAIL en_fourth: got z=%0b zval=%0b expected z=1 zval=1", z_a, zv_a);
      end
      step(1, 0);
      n_vec++; if (z_a !== 1'b0 || zv_a !== 1'b1 || run_a !== 3'd4) begin
         n_err++; $display("FAIL en_off_after_match: got z=%0b zval=%0b run=%0d expected z=0 zval=1 run=4", z_a, zv_a, run_a);
      end
      step(0, 1);
      n_vec++; if (z_a !== 1'b0 || run_a !== 3'd1) begin
         n_err++; $display("FAIL en_break: got z=%0b run=%0d expected z=0 run=1", z_a, run_a);
      end
   endtask

   task automatic test_saturation();
      mode = 2'b11; overlap = 1'b1; clr_count = 1'b0;
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         step(1, 1);
         if (i == 5) begin
            n_vec++; if (cnt_b !== 2'd2 || sat_b !== 1'b0) begin
               n_err++; $display("FAIL sat_pre: got cnt=%0d sat=%0b expected cnt=2 sat=0", cnt_b, sat_b);
            end
         end
         if (i == 6) begin
            n_vec++; if (cnt_b !== 2'd3 || sat_b !== 1'b1) begin
               n_err++; $display("FAIL sat_reach: got cnt=%0d sat=%0b expected cnt=3 sat=1", cnt_b, sat_b);
            end
         end
      end
      n_vec++; if (cnt_b !== 2'd3 || sat_b !== 1'b1 || cnt_a !== 8'd5) begin
         n_err++; $display("FAIL sat_hold: got cntb=%0d sat=%0b cnta=%0d expected cntb=3 sat=1 cnta=5", cnt_b, sat_b, cnt_a);
      end
      clr_count = 1'b1;
      step(1, 1);
      n_vec++; if (cnt_b !== 2'd0 || sat_b !== 1'b0 || z_b !== 1'b1 || cnt_a !== 8'd0) begin
         n_err++; $display("FAIL clr_prio: got cnt=%0d sat=%0b z=%0b cnta=%0d expected cnt=0 sat=0 z=1 cnta=0", cnt_b, sat_b, z_b, cnt_a);
      end
      clr_count = 1'b0;
      step(1, 1);
      n_vec++; if (cnt_b !== 2'd1 || sat_b !== 1'b0) begin
         n_err++; $display("FAIL clr_resume: got cnt=%0d sat=%0b expected cnt=1 sat=0", cnt_b, sat_b);
      end
   endtask

   task automatic test_run_len_one();
      logic [3:0] pat;
      mode = 2'b01; overlap = 1'b1; clr_count = 1'b0;
      do_reset();
      pat = 4'b1101;
      for (int i = 0; i < 4; i++) begin
         step(pat[i], 1);
         n_vec++; if (z_c !== pat[i] || run_c !== 1'b1) begin
            n_err++; $display("FAIL rl1_edge%0d: got z=%0b run=%0d expected z=%0b run=1", i, z_c, run_c, pat[i]);
         end
      end
      n_vec++; if (cnt_c !== 8'd3) begin
         n_err++; $display("FAIL rl1_count: got %0d expected 3", cnt_c);
      end
   endtask

   initial begin
      resetn = 1'b0; en = 1'b0; w = 1'b0; mode = 2'b11; overlap = 1'b1; clr_count = 1'b0;
      test_reset();
      test_overlap();
      test_nonoverlap();
      test_mode();
      test_enable();
      test_saturation();
      test_run_len_one();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
